// File: rtl/input_command_decoder_if.sv
// Board-side bundle for the input decoder: raw keys/switches in, clean counter controls out.
interface input_command_decoder_if;
  logic [3:0] i_key;
  logic [1:0] i_sw;
  logic       set;
  logic       shift_left2;
  logic       shift_right1;
  logic       input_pause;
  logic       dcrm;
  logic       nsyst;
  logic [2:0] pending;

  modport master (
    output i_key, i_sw,
    input  set, shift_left2, shift_right1, input_pause, dcrm, nsyst, pending
  );

  modport slave (
    input  i_key, i_sw,
    output set, shift_left2, shift_right1, input_pause, dcrm, nsyst, pending
  );
endinterface

// File: rtl/input_command_decoder.sv
// Turns raw board keys/switches into synchronised, debounced command pulses and levels
// for the counter; simultaneous key presses are serialised one pulse per cycle.
module input_command_decoder #(
  parameter int unsigned p_debounce_cycles = 20000,
  parameter bit          p_key_active_low  = 1'b1
) (
  input logic                   i_clk,
  input logic                   reset,
  input_command_decoder_if.slave bus
);
  localparam int unsigned           CntW    = $clog2(p_debounce_cycles) + 1;
  localparam logic [CntW-1:0]       CntLast = CntW'(p_debounce_cycles - 1);

  typedef enum logic {STABLE, CHANGING} dbState_e;

  logic [5:0]      rawNorm;
  logic [5:0]      sync1_q, sync2_q;
  logic [5:0]      deb_q;
  logic [5:0]      commit;
  dbState_e        dbState_q [6];
  logic [CntW-1:0] dbCnt_q [6];
  logic [2:0]      pending_q, pending_d;
  logic [2:0]      grant, pressCommit, pulse_q;
  logic            pause_q, pauseArm_q, dcrm_q, nsyst_q;

  // Channel order: [3:0] keys normalised to 1=pressed, [5:4] switches.
  always_comb begin
    rawNorm = {bus.i_sw, (p_key_active_low ? ~bus.i_key : bus.i_key)};
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= rawNorm;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    commit = '0;
    for (int i = 0; i < 6; i++) begin
      commit[i] = (dbState_q[i] == CHANGING) && (sync2_q[i] != deb_q[i]) &&
                  (dbCnt_q[i] == CntLast);
    end
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      deb_q <= '0;
      for (int i = 0; i < 6; i++) begin
        dbState_q[i] <= STABLE;
        dbCnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        case (dbState_q[i])
          STABLE: begin
            if (sync2_q[i] != deb_q[i]) begin
              dbState_q[i] <= CHANGING;
              dbCnt_q[i]   <= CntW'(1);
            end else begin
              dbCnt_q[i]   <= '0;
            end
          end
          CHANGING: begin
            if (sync2_q[i] == deb_q[i]) begin
              dbState_q[i] <= STABLE;
              dbCnt_q[i]   <= '0;
            end else if (commit[i]) begin
              deb_q[i]     <= ~deb_q[i];
              dbState_q[i] <= STABLE;
              dbCnt_q[i]   <= '0;
            end else begin
              dbCnt_q[i]   <= dbCnt_q[i] + CntW'(1);
            end
          end
          default: begin
            dbState_q[i] <= STABLE;
            dbCnt_q[i]   <= '0;
          end
        endcase
      end
    end
  end

  // A press committed in the same cycle its bit is granted stays pending for one more pulse.
  always_comb begin
    grant = '0;
    if (pending_q[0])      grant = 3'b001;
    else if (pending_q[1]) grant = 3'b010;
    else if (pending_q[2]) grant = 3'b100;
    pressCommit = commit[2:0] & ~deb_q[2:0];
    pending_d   = (pending_q & ~grant) | pressCommit;
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      pending_q  <= '0;
      pulse_q    <= '0;
      pauseArm_q <= 1'b0;
      pause_q    <= 1'b0;
      dcrm_q     <= 1'b0;
      nsyst_q    <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      pulse_q    <= grant;
      pauseArm_q <= commit[3] & ~deb_q[3];
      pause_q    <= pause_q ^ pauseArm_q;
      dcrm_q     <= deb_q[4];
      nsyst_q    <= deb_q[5];
    end
  end

  assign bus.set          = pulse_q[0];
  assign bus.shift_left2  = pulse_q[1];
  assign bus.shift_right1 = pulse_q[2];
  assign bus.input_pause  = pause_q;
  assign bus.dcrm         = dcrm_q;
  assign bus.nsyst        = nsyst_q;
  assign bus.pending      = pending_q;
endmodule

// File: tb/tb_input_command_decoder.sv
// Self-checking bench for input_command_decoder: directed vector table, hand-written
// latency/corner sequences, and random stimulus compared against a window-based model.
module tb_input_command_decoder;
  localparam int P = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  input_command_decoder_if bus ();

  input_command_decoder #(
    .p_debounce_cycles(P),
    .p_key_active_low (1'b1)
  ) dut (
    .i_clk(clk),
    .reset(rst),
    .bus  (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  bit checkOn    = 1'b0;

  typedef struct {
    logic [3:0] key;
    logic [1:0] sw;
    int         hold;
    logic       expPause;
    logic       expDcrm;
    logic       expNsyst;
    int         expSet;
    int         expL2;
    int         expR1;
  } vec_t;

  vec_t vecs [9];

  int         obsCount [3];
  int         obsFirst [3];
  logic [2:0] obsPendOr;
  logic [2:0] pendAt  [64];
  logic       pauseAt [64];
  logic       dcrmAt  [64];
  logic       nsystAt [64];

  // Reference model: a level is accepted once P consecutive synchronised samples
  // (raw input delayed by two clocks) all disagree with the current accepted level.
  logic [5:0] delayQ [$];
  logic [5:0] win    [$];
  logic [5:0] mDeb;
  logic [2:0] mPending, mPulse;
  logic       mPause, mPauseArm, mDcrm, mNsyst;

  always @(posedge clk) begin : modelBlk
    logic [5:0] raw, seen, commit, debOld;
    logic [2:0] grant;
    bit         allDiff;
    raw = {bus.i_sw, ~bus.i_key};
    if (rst) begin
      delayQ.delete();
      delayQ.push_back(6'd0);
      delayQ.push_back(6'd0);
      win.delete();
      mDeb      = '0;
      mPending  = '0;
      mPulse    = '0;
      mPause    = 1'b0;
      mPauseArm = 1'b0;
      mDcrm     = 1'b0;
      mNsyst    = 1'b0;
    end else begin
      seen = delayQ.pop_front();
      delayQ.push_back(raw);
      win.push_back(seen);
      if (win.size() > P) void'(win.pop_front());
      debOld = mDeb;
      commit = '0;
      if (win.size() == P) begin
        for (int ch = 0; ch < 6; ch++) begin
          allDiff = 1'b1;
          foreach (win[k]) if (win[k][ch] == debOld[ch]) allDiff = 1'b0;
          if (allDiff) begin
            commit[ch] = 1'b1;
            mDeb[ch]   = ~debOld[ch];
          end
        end
      end
      grant = '0;
      for (int b = 0; b < 3; b++) begin
        if (mPending[b]) begin
          grant[b] = 1'b1;
          break;
        end
      end
      mPulse    = grant;
      mPending  = (mPending & ~grant) | (commit[2:0] & mDeb[2:0]);
      mPause    = mPause ^ mPauseArm;
      mPauseArm = commit[3] & mDeb[3];
      mDcrm     = debOld[4];
      mNsyst    = debOld[5];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("model_set",     32'(bus.set),          32'(mPulse[0]));
      checkOutput("model_sl2",     32'(bus.shift_left2),  32'(mPulse[1]));
      checkOutput("model_sr1",     32'(bus.shift_right1), 32'(mPulse[2]));
      checkOutput("model_pause",   32'(bus.input_pause),  32'(mPause));
      checkOutput("model_dcrm",    32'(bus.dcrm),         32'(mDcrm));
      checkOutput("model_nsyst",   32'(bus.nsyst),        32'(mNsyst));
      checkOutput("model_pending", 32'(bus.pending),      32'(mPending));
      checkOutput("onehot_pulse",
                  32'($countones({bus.shift_right1, bus.shift_left2, bus.set}) <= 1), 32'd1);
    end
  end

  task automatic applyStimulus(input logic [3:0] key, input logic [1:0] sw);
    bus.i_key = key;
    bus.i_sw  = sw;
  endtask

  task automatic clearObs();
    for (int b = 0; b < 3; b++) begin
      obsCount[b] = 0;
      obsFirst[b] = -1;
    end
    obsPendOr = '0;
  endtask

  task automatic observe(input int n);
    logic [2:0] pulses;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      pulses = {bus.shift_right1, bus.shift_left2, bus.set};
      for (int b = 0; b < 3; b++) begin
        if (pulses[b]) begin
          obsCount[b]++;
          if (obsFirst[b] < 0) obsFirst[b] = c;
        end
      end
      obsPendOr = obsPendOr | bus.pending;
      if (c < 64) begin
        pendAt[c]  = bus.pending;
        pauseAt[c] = bus.input_pause;
        dcrmAt[c]  = bus.dcrm;
        nsystAt[c] = bus.nsyst;
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{4'b1111, 2'b00, 12, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vecs[1] = '{4'b1101, 2'b01, 12, 1'b0, 1'b1, 1'b0, 0, 1, 0};
    vecs[2] = '{4'b1111, 2'b01, 12, 1'b0, 1'b1, 1'b0, 0, 0, 0};
    vecs[3] = '{4'b0011, 2'b10, 12, 1'b1, 1'b0, 1'b1, 0, 0, 1};
    vecs[4] = '{4'b1111, 2'b10, 12, 1'b1, 1'b0, 1'b1, 0, 0, 0};
    vecs[5] = '{4'b0110, 2'b11, 12, 1'b0, 1'b1, 1'b1, 1, 0, 0};
    vecs[6] = '{4'b1111, 2'b00, 12, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vecs[7] = '{4'b1000, 2'b00, 12, 1'b0, 1'b0, 1'b0, 1, 1, 1};
    vecs[8] = '{4'b1111, 2'b00, 12, 1'b0, 1'b0, 1'b0, 0, 0, 0};

    // Reset with all keys released
    applyStimulus(4'b1111, 2'b00);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_pulses",  32'({bus.shift_right1, bus.shift_left2, bus.set}), 32'd0);
    checkOutput("reset_levels",  32'({bus.input_pause, bus.dcrm, bus.nsyst}), 32'd0);
    checkOutput("reset_pending", 32'(bus.pending), 32'd0);
    rst     = 1'b0;
    checkOn = 1'b1;
    clearObs();
    observe(20);
    checkOutput("quiet_pulses",  32'(obsCount[0] + obsCount[1] + obsCount[2]), 32'd0);
    checkOutput("quiet_pending", 32'(obsPendOr), 32'd0);

    // Table-driven vectors
    for (int v = 0; v < 9; v++) begin
      clearObs();
      applyStimulus(vecs[v].key, vecs[v].sw);
      observe(vecs[v].hold);
      checkOutput($sformatf("vec%0d_set", v),     32'(obsCount[0]),    32'(vecs[v].expSet));
      checkOutput($sformatf("vec%0d_sl2", v),     32'(obsCount[1]),    32'(vecs[v].expL2));
      checkOutput($sformatf("vec%0d_sr1", v),     32'(obsCount[2]),    32'(vecs[v].expR1));
      checkOutput($sformatf("vec%0d_pause", v),   32'(bus.input_pause), 32'(vecs[v].expPause));
      checkOutput($sformatf("vec%0d_dcrm", v),    32'(bus.dcrm),       32'(vecs[v].expDcrm));
      checkOutput($sformatf("vec%0d_nsyst", v),   32'(bus.nsyst),      32'(vecs[v].expNsyst));
      checkOutput($sformatf("vec%0d_pending", v), 32'(bus.pending),    32'd0);
    end

    // Clean press of key[0], then release
    clearObs();
    applyStimulus(4'b1110, 2'b00);
    observe(20);
    checkOutput("clean_set_count",   32'(obsCount[0]), 32'd1);
    checkOutput("clean_set_latency", 32'(obsFirst[0]), 32'd7);
    checkOutput("clean_other",       32'(obsCount[1] + obsCount[2]), 32'd0);
    clearObs();
    applyStimulus(4'b1111, 2'b00);
    observe(20);
    checkOutput("release_no_pulse",  32'(obsCount[0] + obsCount[1] + obsCount[2]), 32'd0);

    // Bouncing key[1]: 2-cycle segments must all be rejected
    clearObs();
    for (int s = 0; s < 6; s++) begin
      applyStimulus((s % 2 == 0) ? 4'b1101 : 4'b1111, 2'b00);
      observe(2);
    end
    checkOutput("bounce_no_pulse", 32'(obsCount[0] + obsCount[1] + obsCount[2]), 32'd0);
    clearObs();
    applyStimulus(4'b1101, 2'b00);
    observe(20);
    checkOutput("bounce_sl2_count",   32'(obsCount[1]), 32'd1);
    checkOutput("bounce_sl2_latency", 32'(obsFirst[1]), 32'd7);
    applyStimulus(4'b1111, 2'b00);
    observe(20);

    // Simultaneous press of keys 0..2
    clearObs();
    applyStimulus(4'b1000, 2'b00);
    observe(20);
    checkOutput("simul_set_at", 32'(obsFirst[0]), 32'd7);
    checkOutput("simul_sl2_at", 32'(obsFirst[1]), 32'd8);
    checkOutput("simul_sr1_at", 32'(obsFirst[2]), 32'd9);
    checkOutput("simul_counts", 32'(obsCount[0] + obsCount[1] + obsCount[2]), 32'd3);
    checkOutput("simul_pend6",  32'(pendAt[6]), 32'b111);
    checkOutput("simul_pend7",  32'(pendAt[7]), 32'b110);
    checkOutput("simul_pend8",  32'(pendAt[8]), 32'b100);
    checkOutput("simul_pend9",  32'(pendAt[9]), 32'b000);
    applyStimulus(4'b1111, 2'b00);
    observe(20);

    // Pause toggles on three presses
    for (int pr = 0; pr < 3; pr++) begin
      applyStimulus(4'b0111, 2'b00);
      observe(10);
      if (pr == 0) begin
        checkOutput("pause_before", 32'(pauseAt[6]), 32'd0);
        checkOutput("pause_after",  32'(pauseAt[7]), 32'd1);
      end
      checkOutput($sformatf("pause_press%0d", pr), 32'(bus.input_pause), 32'((pr % 2) == 0));
      applyStimulus(4'b1111, 2'b00);
      observe(10);
      checkOutput($sformatf("pause_hold%0d", pr), 32'(bus.input_pause), 32'((pr % 2) == 0));
    end

    // Switches
    applyStimulus(4'b1111, 2'b11);
    observe(12);
    checkOutput("sw_dcrm_before", 32'(dcrmAt[6]),  32'd0);
    checkOutput("sw_dcrm_after",  32'(dcrmAt[7]),  32'd1);
    checkOutput("sw_nsyst_after", 32'(nsystAt[7]), 32'd1);
    applyStimulus(4'b1111, 2'b00);
    observe(12);
    checkOutput("sw_off", 32'({bus.dcrm, bus.nsyst}), 32'd0);

    // Reset three cycles into a key[0] debounce, key kept held
    clearObs();
    applyStimulus(4'b1110, 2'b00);
    observe(3);
    rst = 1'b1;
    observe(1);
    checkOutput("rstmid_pending", 32'(bus.pending), 32'd0);
    checkOutput("rstmid_nopulse", 32'(obsCount[0]), 32'd0);
    rst = 1'b0;
    clearObs();
    observe(20);
    checkOutput("rstmid_set_count",   32'(obsCount[0]), 32'd1);
    checkOutput("rstmid_set_latency", 32'(obsFirst[0]), 32'd7);
    applyStimulus(4'b1111, 2'b00);
    observe(20);

    // Random stimulus, checked cycle by cycle against the model
    for (int n = 0; n < 120; n++) begin
      applyStimulus(4'($urandom), 2'($urandom));
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      repeat ($urandom_range(1, 10)) @(negedge clk);
    end
    applyStimulus(4'b1111, 2'b00);
    repeat (30) @(negedge clk);

    checkOn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
